// File: rtl/vec_issue_ctrl.sv
// Vector-instruction issue controller: buffers core vector instructions in a FIFO,
// fetches the scalar rs1 operand when needed and issues to the coprocessor over valid/ready.
module vec_issue_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [XLEN-1:0]          core_instr,
    input  logic                     core_valid,
    output logic                     core_stall,
    input  logic                     flush,
    output logic [REG_BITS-1:0]      v_rd_xreg_addr,
    input  logic [XLEN-1:0]          xreg_out,
    output logic [XLEN-1:0]          v_instr,
    output logic [XLEN-1:0]          v_xop,
    output logic                     v_valid,
    input  logic                     v_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH_X = 2'd1;
    localparam logic [1:0] S_ISSUE   = 2'd2;

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] xop_q, xop_d;
    logic            overflow_q, overflow_d;

    logic            full, empty, push, pop;
    logic [XLEN-1:0] head;

    function automatic logic need_x(input logic [6:0] opcode, input logic [2:0] funct3);
        logic r;
        r = 1'b0;
        if (opcode == 7'h57)
            r = (funct3 == 3'b100) || (funct3 == 3'b110) || (funct3 == 3'b111);
        else if (opcode == 7'h07 || opcode == 7'h27)
            r = 1'b1;
        return r;
    endfunction

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = core_valid & ~full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop loads the output register from either IDLE or a completed ISSUE handshake.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        xop_d   = xop_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    instr_d = head;
                    if (need_x(head[6:0], head[14:12])) begin
                        state_d = S_FETCH_X;
                    end else begin
                        state_d = S_ISSUE;
                        xop_d   = '0;
                    end
                end
            end
            S_FETCH_X: begin
                xop_d   = xreg_out;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (v_ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        instr_d = head;
                        if (need_x(head[6:0], head[14:12])) begin
                            state_d = S_FETCH_X;
                        end else begin
                            xop_d = '0;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d   = rd_ptr_q + (AW+1)'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q | (core_valid & full);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= core_instr;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= S_IDLE;
            instr_q    <= '0;
            xop_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            instr_q    <= instr_d;
            xop_q      <= xop_d;
            overflow_q <= overflow_d;
        end
    end

    assign core_stall     = full;
    assign count          = count_q;
    assign overflow       = overflow_q;
    assign v_valid        = (state_q == S_ISSUE);
    assign v_instr        = instr_q;
    assign v_xop          = xop_q;
    assign v_rd_xreg_addr = (state_q == S_FETCH_X) ? instr_q[15 +: REG_BITS] : '0;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl: expected instr/operand pairs are queued at push
// and compared when the coprocessor handshake completes.
module tb_vec_issue_ctrl;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] xop;
    } exp_t;

    logic        clk = 1'b0;
    logic        nrst;
    logic [31:0] core_instr;
    logic        core_valid;
    logic        core_stall;
    logic        flush;
    logic [4:0]  v_rd_xreg_addr;
    logic [31:0] xreg_out;
    logic [31:0] v_instr;
    logic [31:0] v_xop;
    logic        v_valid;
    logic        v_ready;
    logic [2:0]  count;
    logic        overflow;

    logic [31:0] xregs [32];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          hs_cnt = 0;

    localparam logic [31:0] VADD_VV = 32'h0220_8057;
    localparam logic [31:0] VADD_VX = 32'h0202_C057;

    vec_issue_ctrl #(.DEPTH(4), .XLEN(32), .REG_BITS(5)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .core_instr     (core_instr),
        .core_valid     (core_valid),
        .core_stall     (core_stall),
        .flush          (flush),
        .v_rd_xreg_addr (v_rd_xreg_addr),
        .xreg_out       (xreg_out),
        .v_instr        (v_instr),
        .v_xop          (v_xop),
        .v_valid        (v_valid),
        .v_ready        (v_ready),
        .count          (count),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;
    assign xreg_out = xregs[v_rd_xreg_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (nrst && v_valid && v_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                check("spurious_issue", 32'(sb.size()), 32'd1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("issue_instr", v_instr, e.instr);
                check("issue_xop", v_xop, e.xop);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] xop, input bit expect_it);
        core_instr = instr;
        core_valid = 1'b1;
        if (expect_it) sb.push_back('{instr: instr, xop: xop});
        step();
        core_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) step();
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int hs0;
        for (int i = 0; i < 32; i++) xregs[i] = 32'h0101_0101 * i;
        xregs[5]   = 32'hDEAD_BEEF;
        nrst       = 1'b0;
        core_instr = '0;
        core_valid = 1'b0;
        flush      = 1'b0;
        v_ready    = 1'b0;

        // Reset state
        #12;
        check("rst_v_valid", 32'(v_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_stall", 32'(core_stall), 32'd0);
        check("rst_v_instr", v_instr, 32'd0);
        check("rst_v_xop", v_xop, 32'd0);
        check("rst_addr", 32'(v_rd_xreg_addr), 32'd0);
        nrst = 1'b1;
        step();

        // Single no-x instruction
        v_ready = 1'b1;
        hs0 = hs_cnt;
        push_one(VADD_VV, 32'd0, 1'b1);
        check("nox_count_after_push", 32'(count), 32'd1);
        check("nox_valid_n", 32'(v_valid), 32'd0);
        step();
        check("nox_valid_n1", 32'(v_valid), 32'd1);
        check("nox_instr", v_instr, VADD_VV);
        check("nox_xop", v_xop, 32'd0);
        step();
        check("nox_valid_n2", 32'(v_valid), 32'd0);
        check("nox_count_end", 32'(count), 32'd0);
        check("nox_handshakes", 32'(hs_cnt - hs0), 32'd1);

        // Single need-x instruction, rs1 = x5
        push_one(VADD_VX, 32'hDEAD_BEEF, 1'b1);
        check("x_valid_n", 32'(v_valid), 32'd0);
        step();
        check("x_fetch_addr", 32'(v_rd_xreg_addr), 32'd5);
        check("x_fetch_valid", 32'(v_valid), 32'd0);
        step();
        check("x_issue_valid", 32'(v_valid), 32'd1);
        check("x_issue_xop", v_xop, 32'hDEAD_BEEF);
        check("x_issue_addr", 32'(v_rd_xreg_addr), 32'd0);
        step();
        check("x_done_valid", 32'(v_valid), 32'd0);

        // Fill to full with v_ready low, overflow on the sixth push, then hold stability
        v_ready = 1'b0;
        hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) push_one(VADD_VV + (32'(i) << 7), 32'd0, 1'b1);
        check("full_stall", 32'(core_stall), 32'd1);
        check("full_count", 32'(count), 32'd4);
        check("full_no_ovf_yet", 32'(overflow), 32'd0);
        push_one(32'h0FFF_F057, 32'd0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        for (int i = 0; i < 3; i++) begin
            check("hold_valid", 32'(v_valid), 32'd1);
            check("hold_instr", v_instr, VADD_VV);
            check("hold_xop", v_xop, 32'd0);
            step();
        end
        check("hold_no_hs", 32'(hs_cnt - hs0), 32'd0);
        v_ready = 1'b1;
        drain("full_drain");
        step();
        check("full_handshakes", 32'(hs_cnt - hs0), 32'd5);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("full_count_end", 32'(count), 32'd0);

        // Flush during FETCH_X with three buffered
        v_ready = 1'b0;
        push_one(VADD_VX, 32'hDEAD_BEEF, 1'b1);
        for (int i = 1; i < 5; i++) push_one(VADD_VX + (32'(i) << 7), 32'd0, 1'b0);
        check("fl_count_pre", 32'(count), 32'd4);
        check("fl_valid_pre", 32'(v_valid), 32'd1);
        v_ready = 1'b1;
        step();
        v_ready = 1'b0;
        check("fl_count_fetch", 32'(count), 32'd3);
        check("fl_fetch_addr", 32'(v_rd_xreg_addr), 32'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fl_count", 32'(count), 32'd0);
        check("fl_valid", 32'(v_valid), 32'd0);
        check("fl_addr", 32'(v_rd_xreg_addr), 32'd0);
        check("fl_stall", 32'(core_stall), 32'd0);
        step();
        check("fl_idle_valid", 32'(v_valid), 32'd0);
        v_ready = 1'b1;
        push_one(32'h0240_8057, 32'd0, 1'b1);
        drain("fl_post_drain");

        // Asynchronous reset mid-ISSUE
        v_ready = 1'b0;
        push_one(VADD_VV, 32'd0, 1'b0);
        push_one(VADD_VV, 32'd0, 1'b0);
        check("ar_valid_pre", 32'(v_valid), 32'd1);
        check("ar_count_pre", 32'(count), 32'd1);
        #3;
        nrst = 1'b0;
        #1;
        check("ar_valid", 32'(v_valid), 32'd0);
        check("ar_count", 32'(count), 32'd0);
        check("ar_overflow", 32'(overflow), 32'd0);
        check("ar_instr", v_instr, 32'd0);
        #2;
        nrst = 1'b1;
        step();
        check("end_scoreboard", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
